noc_node_interface: RTL and testbench
=====================================

# noc_node_interface

Network interface for one HNoC endpoint. It packs local payload words into 32-bit flits carrying an 8-bit destination in bits [31:24] and injects them into one switch port. It takes flits from the same switch port, accepts the ones addressed to this node, drops misrouted ones and counts events. Both directions are buffered with valid/ready handshakes so the local core and the switch never stall each other combinationally.

## Interface
- DataWidth, 32: flit width; fixed at 32 (bits [31:24] destination, [23:0] payload).
- NodeId, 0: 8-bit address of this node; incoming flits with [31:24] == NodeId are delivered locally.
- TxDepth, 4: transmit FIFO depth in flits; power of two, at least 2.
- RxDepth, 4: receive FIFO depth in flits; power of two, at least 2.

Ports:
- i_clk  in  1  single clock; all logic is rising-edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_tx_payload  in  24  local payload word.
- i_tx_dest  in  8  destination node id for i_tx_payload.
- i_tx_valid  in  1  local transmit request.
- o_tx_ready  out  1  transmit FIFO can accept a word.
- o_data  out  32  flit to switch, {dest, payload}.
- o_data_valid  out  1  o_data holds a flit.
- i_data_ready  in  1  switch accepts o_data.
- i_data  in  32  flit from switch.
- i_data_valid  in  1  i_data holds a flit.
- o_data_ready  out  1  interface accepts i_data.
- o_rx_payload  out  24  delivered payload, i_data[23:0] of an accepted flit.
- o_rx_valid  out  1  o_rx_payload valid.
- i_rx_ready  in  1  local core accepts o_rx_payload.
- o_tx_count  out  16  flits handed to the switch.
- o_rx_count  out  16  flits delivered to the local core.
- o_drop_count  out  16  misrouted flits dropped.

## Operation
- Transmit path:
  - Handshake i_tx_valid & o_tx_ready pushes {i_tx_dest, i_tx_payload} into the TX FIFO.
  - The FIFO head drives o_data.
  - o_data_valid = TX FIFO not empty.
  - Handshake o_data_valid & i_data_ready pops the head and increments o_tx_count.
- Receive path:
  - Handshake i_data_valid & o_data_ready samples i_data.
  - If i_data[31:24] == NodeId, payload [23:0] is pushed into the RX FIFO.
  - Otherwise the flit is discarded and o_drop_count increments.
  - The RX FIFO head drives o_rx_payload; o_rx_valid = RX FIFO not empty.
  - Handshake o_rx_valid & i_rx_ready pops the head and increments o_rx_count.
- FIFOs:
  - Circular buffer; read/write pointers are log2(Depth)+1 bits, with the MSB used to tell full from empty.
  - Pointers wrap modulo 2*Depth.
  - Storage array is not reset.
- o_tx_ready = !tx_full and o_data_ready = !rx_full. Both depend only on occupancy, never on same-cycle valid or ready inputs.
- The drop path is also gated by o_data_ready, so drops stall while the RX FIFO is full.
- Counters are 16-bit, saturate at 0xFFFF and do not wrap.
- A transmit to dest == NodeId is sent to the network like any other flit.

## Timing
- Reset (async assert, sync deassert handled externally):
  - Both FIFOs empty.
  - o_data_valid=0, o_rx_valid=0.
  - o_tx_ready=1, o_data_ready=1.
  - All counters 0.
  - o_data and o_rx_payload are don't-care while their valid is low.
- Reset asserted mid-operation clears all stored flits immediately. In-flight flits are lost; counters are not preserved.
- Latency:
  - A word accepted at edge N appears on o_data with o_data_valid=1 after edge N (1 cycle). The same holds for i_data to o_rx_payload.
  - There is no combinational path from any input valid to any output valid.
- Full FIFO with a simultaneous pop: ready stays 0 that cycle and there is no push. Ready rises the cycle after the pop.
- Empty FIFO with a simultaneous push: valid rises next cycle; no bypass.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy unchanged and order preserved.
- o_data and o_rx_payload stay stable while valid=1 and ready=0.
- Counters update on the edge of the qualifying handshake and are visible the next cycle.

## Test plan
- **Reset values:** hold i_reset_n=0, then release. Required: valids 0, readies 1, counters 0. Asserting reset with 3 flits queued clears o_data_valid within the same cycle.
- **TX stream and backpressure:** push payloads 0x000001..0x000005 to dest 0x02 with i_data_ready=0. Required: o_tx_ready drops after 4 accepts. Then raise i_data_ready: o_data sequence is 0x02000001..0x02000004, then the 5th word after re-push, and o_tx_count=5.
- **RX delivery:** with NodeId=3, send 0x03ABCDEF. Required: o_rx_payload=0xABCDEF with o_rx_valid=1 one cycle later, and o_rx_count=1 after the pop.
- **Misroute drop:** with NodeId=3, send 0x05123456 then 0x03000010. Required: only 0x000010 is delivered, o_drop_count=1, o_rx_count=1.
- **RX full:** hold i_rx_ready=0 and send 5 matching flits. Required: o_data_ready=0 after 4 are accepted, and the 5th is held by the switch. One pop re-enables o_data_ready on the next cycle, and FIFO order is preserved.
- **Counter saturation:** force 65537 TX handshakes. Required: o_tx_count holds 0xFFFF.

Source files
------------

// File: rtl/noc_node_interface_if.sv
// Local-core and switch-port signals of one NoC endpoint.
// The slave modport is the node's view; master is the core/switch side.
interface noc_node_interface_if;
   logic [23:0] i_tx_payload;
   logic [7:0]  i_tx_dest;
   logic        i_tx_valid;
   logic        o_tx_ready;
   logic [31:0] o_data;
   logic        o_data_valid;
   logic        i_data_ready;
   logic [31:0] i_data;
   logic        i_data_valid;
   logic        o_data_ready;
   logic [23:0] o_rx_payload;
   logic        o_rx_valid;
   logic        i_rx_ready;

   modport slave (
      input  i_tx_payload, i_tx_dest, i_tx_valid, i_data_ready,
      input  i_data, i_data_valid, i_rx_ready,
      output o_tx_ready, o_data, o_data_valid, o_data_ready,
      output o_rx_payload, o_rx_valid
   );

   modport master (
      output i_tx_payload, i_tx_dest, i_tx_valid, i_data_ready,
      output i_data, i_data_valid, i_rx_ready,
      input  o_tx_ready, o_data, o_data_valid, o_data_ready,
      input  o_rx_payload, o_rx_valid
   );
endinterface

// File: rtl/noc_node_interface.sv
// NoC endpoint: packs payloads into {dest,payload} flits, filters incoming flits by NodeId.
// One-cycle latency each way through a FIFO; readies depend only on FIFO occupancy.
module noc_node_interface_fifo #(
   parameter int Width = 32,
   parameter int Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(Depth);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic             push, pop;

   // Extra pointer MSB distinguishes a full buffer from an empty one.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push    = push_i && !full_o;
   assign pop     = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

module noc_node_interface #(
   parameter int         DataWidth = 32,
   parameter logic [7:0] NodeId    = 8'd0,
   parameter int         TxDepth   = 4,
   parameter int         RxDepth   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   noc_node_interface_if.slave  bus,
   output logic [15:0]          o_tx_count,
   output logic [15:0]          o_rx_count,
   output logic [15:0]          o_drop_count
);
   logic [DataWidth-1:0] tx_flit, tx_head;
   logic                 tx_full, tx_empty, tx_push, tx_pop;
   logic                 rx_full, rx_empty, rx_hs, rx_match, rx_push, rx_pop, drop;
   logic [15:0]          tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;

   assign tx_flit = {bus.i_tx_dest, bus.i_tx_payload};
   assign tx_push = bus.i_tx_valid && !tx_full;
   assign tx_pop  = !tx_empty && bus.i_data_ready;

   noc_node_interface_fifo #(.Width(DataWidth), .Depth(TxDepth)) u_tx_fifo (
      .clk_i(i_clk), .rst_ni(i_reset_n), .push_i(tx_push), .wdata_i(tx_flit),
      .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
   );

   assign bus.o_tx_ready   = !tx_full;
   assign bus.o_data       = tx_head;
   assign bus.o_data_valid = !tx_empty;

   // Misrouted flits are only consumed while the RX FIFO has room.
   assign rx_hs    = bus.i_data_valid && !rx_full;
   assign rx_match = (bus.i_data[31:24] == NodeId);
   assign rx_push  = rx_hs && rx_match;
   assign drop     = rx_hs && !rx_match;
   assign rx_pop   = !rx_empty && bus.i_rx_ready;

   noc_node_interface_fifo #(.Width(24), .Depth(RxDepth)) u_rx_fifo (
      .clk_i(i_clk), .rst_ni(i_reset_n), .push_i(rx_push), .wdata_i(bus.i_data[23:0]),
      .pop_i(rx_pop), .rdata_o(bus.o_rx_payload), .full_o(rx_full), .empty_o(rx_empty)
   );

   assign bus.o_data_ready = !rx_full;
   assign bus.o_rx_valid   = !rx_empty;

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
      return (inc && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
   endfunction

   assign tx_cnt_d   = sat_inc(tx_cnt_q, tx_pop);
   assign rx_cnt_d   = sat_inc(rx_cnt_q, rx_pop);
   assign drop_cnt_d = sat_inc(drop_cnt_q, drop);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_tx_count   = tx_cnt_q;
   assign o_rx_count   = rx_cnt_q;
   assign o_drop_count = drop_cnt_q;
endmodule

// File: tb/tb_noc_node_interface.sv
// Directed bench for noc_node_interface (NodeId=3) with TX/RX scoreboards.
module tb_noc_node_interface;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] tx_cnt, rx_cnt, drop_cnt;

   noc_node_interface_if bus();

   noc_node_interface #(.NodeId(8'd3)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus),
      .o_tx_count(tx_cnt), .o_rx_count(rx_cnt), .o_drop_count(drop_cnt)
   );

   always #5 clk = ~clk;

   int          passed = 0;
   int          total  = 0;
   int          tx_hs  = 0;
   logic [31:0] tx_q[$];
   logic [23:0] rx_q[$];
   logic        tx_acc, rx_acc;
   logic [31:0] exp_flit;
   logic [23:0] exp_pay;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Scoreboard bookkeeping happens at the falling edge, before the handshake edge.
   task automatic tick();
      @(negedge clk);
      tx_acc = 1'b0;
      rx_acc = 1'b0;
      if (rst_n) begin
         if (bus.o_data_valid && bus.i_data_ready) begin
            tx_hs++;
            if (tx_q.size() == 0) check("tx_spurious", bus.o_data_valid, 1'b0);
            else begin
               exp_flit = tx_q.pop_front();
               check("tx_order", bus.o_data, exp_flit);
            end
         end
         if (bus.i_tx_valid && bus.o_tx_ready) begin
            tx_q.push_back({bus.i_tx_dest, bus.i_tx_payload});
            tx_acc = 1'b1;
         end
         if (bus.o_rx_valid && bus.i_rx_ready) begin
            if (rx_q.size() == 0) check("rx_spurious", bus.o_rx_valid, 1'b0);
            else begin
               exp_pay = rx_q.pop_front();
               check("rx_order", {8'h0, bus.o_rx_payload}, {8'h0, exp_pay});
            end
         end
         if (bus.i_data_valid && bus.o_data_ready) begin
            rx_acc = 1'b1;
            if (bus.i_data[31:24] == 8'd3) rx_q.push_back(bus.i_data[23:0]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_tx_payload = '0; bus.i_tx_dest = '0; bus.i_tx_valid = 1'b0;
      bus.i_data_ready = 1'b0; bus.i_data = '0; bus.i_data_valid = 1'b0;
      bus.i_rx_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tx_q.delete();
      rx_q.delete();
      tx_hs = 0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic send_tx(input logic [7:0] dest, input logic [23:0] pay);
      bus.i_tx_dest = dest; bus.i_tx_payload = pay; bus.i_tx_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_acc) break;
      end
      check("tx_accept", tx_acc, 1'b1);
      bus.i_tx_valid = 1'b0;
   endtask

   task automatic send_rx(input logic [31:0] flit);
      bus.i_data = flit; bus.i_data_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rx_acc) break;
      end
      check("rx_accept", rx_acc, 1'b1);
      bus.i_data_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (!bus.o_data_valid && !bus.o_rx_valid) break;
         tick();
      end
      check("drain_tx_empty", bus.o_data_valid, 1'b0);
      check("drain_rx_empty", bus.o_rx_valid, 1'b0);
   endtask

   initial begin
      // Reset values
      do_reset();
      check("rst_data_valid", bus.o_data_valid, 1'b0);
      check("rst_rx_valid", bus.o_rx_valid, 1'b0);
      check("rst_tx_ready", bus.o_tx_ready, 1'b1);
      check("rst_data_ready", bus.o_data_ready, 1'b1);
      check("rst_tx_count", tx_cnt, 16'd0);
      check("rst_rx_count", rx_cnt, 16'd0);
      check("rst_drop_count", drop_cnt, 16'd0);

      // TX stream with switch backpressure
      for (int k = 1; k <= 4; k++) send_tx(8'h02, 24'(k));
      check("tx_full_ready", bus.o_tx_ready, 1'b0);
      check("tx_head_valid", bus.o_data_valid, 1'b1);
      check("tx_head", bus.o_data, 32'h0200_0001);
      bus.i_tx_dest = 8'h02; bus.i_tx_payload = 24'h5; bus.i_tx_valid = 1'b1;
      tick();
      check("tx5_held", tx_acc, 1'b0);
      check("tx_head_stable", bus.o_data, 32'h0200_0001);
      bus.i_data_ready = 1'b1;
      tick();
      check("tx_no_push_on_full_pop", tx_acc, 1'b0);
      check("tx_ready_after_pop", bus.o_tx_ready, 1'b1);
      for (int i = 0; i < 20 && !tx_acc; i++) tick();
      check("tx5_accept", tx_acc, 1'b1);
      bus.i_tx_valid = 1'b0;
      drain(20);
      check("tx_count_5", tx_cnt, 16'd5);

      // Reset with flits queued
      bus.i_data_ready = 1'b0;
      for (int k = 0; k < 3; k++) send_tx(8'h07, 24'(k));
      check("pre_rst_valid", bus.o_data_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_data_valid", bus.o_data_valid, 1'b0);
      check("midrst_tx_ready", bus.o_tx_ready, 1'b1);
      check("midrst_tx_count", tx_cnt, 16'd0);
      do_reset();

      // RX delivery
      check("rx_idle_valid", bus.o_rx_valid, 1'b0);
      send_rx(32'h03AB_CDEF);
      check("rx_valid_1cyc", bus.o_rx_valid, 1'b1);
      check("rx_payload", {8'h0, bus.o_rx_payload}, 32'h00AB_CDEF);
      bus.i_rx_ready = 1'b1;
      tick();
      bus.i_rx_ready = 1'b0;
      check("rx_count_1", rx_cnt, 16'd1);
      check("rx_valid_after_pop", bus.o_rx_valid, 1'b0);

      // Misroute drop
      do_reset();
      bus.i_rx_ready = 1'b1;
      send_rx(32'h0512_3456);
      check("drop_no_deliver", bus.o_rx_valid, 1'b0);
      send_rx(32'h0300_0010);
      drain(20);
      check("drop_count", drop_cnt, 16'd1);
      check("drop_rx_count", rx_cnt, 16'd1);

      // RX full with core backpressure
      do_reset();
      for (int k = 0; k < 4; k++) send_rx(32'h0300_0020 + 32'(k));
      check("rx_full_ready", bus.o_data_ready, 1'b0);
      bus.i_data = 32'h0300_0024; bus.i_data_valid = 1'b1;
      tick(); tick(); tick();
      check("rx5_held", rx_acc, 1'b0);
      check("rx_head_stable", {8'h0, bus.o_rx_payload}, 32'h0000_0020);
      bus.i_rx_ready = 1'b1;
      tick();
      check("rx_no_push_on_full_pop", rx_acc, 1'b0);
      check("rx_ready_after_pop", bus.o_data_ready, 1'b1);
      for (int i = 0; i < 20 && !rx_acc; i++) tick();
      check("rx5_accept", rx_acc, 1'b1);
      bus.i_data_valid = 1'b0;
      drain(20);
      check("rx_count_5", rx_cnt, 16'd5);
      check("rx_full_drops", drop_cnt, 16'd0);

      // TX counter saturation
      do_reset();
      bus.i_data_ready = 1'b1;
      bus.i_tx_dest = 8'h09;
      bus.i_tx_valid = 1'b1;
      for (int i = 0; i < 70000 && tx_hs < 65537; i++) begin
         bus.i_tx_payload = 24'(i);
         tick();
         if (tx_hs == 65535) check("tx_count_at_max", tx_cnt, 16'hFFFF);
      end
      bus.i_tx_valid = 1'b0;
      check("sat_hs_reached", (tx_hs >= 65537) ? 1'b1 : 1'b0, 1'b1);
      drain(20);
      check("tx_count_sat", tx_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
